// File: rtl/prefix_addsub_pipe.sv
// Pipelined Sklansky parallel-prefix adder/subtractor with valid/tag side-band.
// A register boundary follows every LPS prefix levels; post-processing is registered at the output.
module prefix_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LPS   = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned N   = $clog2(WIDTH);
  localparam int unsigned S   = (N + LPS - 1) / LPS;
  localparam int unsigned SBW = TAG_W + 1 + WIDTH;

  // Sklansky levels [lo, hi): bits with bit 'lv' of their index set combine
  // with the top bit of the adjacent lower block.
  function automatic logic [WIDTH-1:0] sk_g(input logic [WIDTH-1:0] g,
                                            input logic [WIDTH-1:0] p,
                                            input int unsigned      lo,
                                            input int unsigned      hi);
    logic [WIDTH-1:0] gc, pc, gn, pn;
    int unsigned j;
    gc = g;
    pc = p;
    for (int unsigned lv = lo; lv < hi; lv++) begin
      gn = gc;
      pn = pc;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (((i >> lv) & 1) != 0) begin
          j     = ((i >> lv) << lv) - 1;
          gn[i] = gc[i] | (pc[i] & gc[j]);
          pn[i] = pc[i] & pc[j];
        end
      end
      gc = gn;
      pc = pn;
    end
    return gc;
  endfunction

  function automatic logic [WIDTH-1:0] sk_p(input logic [WIDTH-1:0] p,
                                            input int unsigned      lo,
                                            input int unsigned      hi);
    logic [WIDTH-1:0] pc, pn;
    int unsigned j;
    pc = p;
    for (int unsigned lv = lo; lv < hi; lv++) begin
      pn = pc;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (((i >> lv) & 1) != 0) begin
          j     = ((i >> lv) << lv) - 1;
          pn[i] = pc[i] & pc[j];
        end
      end
      pc = pn;
    end
    return pc;
  endfunction

  logic [WIDTH-1:0] yb, pre_p, pre_g;
  logic             c0;

  // c0 is merged into bit 0's generate so the N-level network yields G[i:-1] directly.
  always_comb begin
    yb       = sub ? ~y : y;
    c0       = cin ^ sub;
    pre_p    = x ^ yb;
    pre_g    = x & yb;
    pre_g[0] = pre_g[0] | (pre_p[0] & c0);
  end

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int unsigned LO = k * LPS;
    localparam int unsigned HI = ((k + 1) * LPS < N) ? (k + 1) * LPS : N;

    logic [WIDTH-1:0] g_in, p_in, g_q;
    logic [SBW-1:0]   sb_in, sb_q;
    logic             v_in, v_q;

    if (k == 0) begin : g_src
      assign g_in  = pre_g;
      assign p_in  = pre_p;
      assign sb_in = {in_tag, c0, pre_p};
      assign v_in  = in_valid;
    end else begin : g_src
      assign g_in  = g_stg[k-1].g_q;
      assign p_in  = g_stg[k-1].g_pq.p_q;
      assign sb_in = g_stg[k-1].sb_q;
      assign v_in  = g_stg[k-1].v_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        g_q  <= sk_g(g_in, p_in, LO, HI);
        sb_q <= sb_in;
      end
    end

    // Group propagate is dead after the final level, so only inner stages keep it.
    if (k < S - 1) begin : g_pq
      logic [WIDTH-1:0] p_q;
      always_ff @(posedge clk) begin
        if (en) begin
          p_q <= sk_p(p_in, LO, HI);
        end
      end
    end
  end

  logic [WIDTH-1:0] g_f, p_f, carry, s_d;
  logic [TAG_W-1:0] tag_f;
  logic             c0_f, v_f, cout_d, ovf_d, zero_d;

  assign g_f                 = g_stg[S-1].g_q;
  assign {tag_f, c0_f, p_f}  = g_stg[S-1].sb_q;
  assign v_f                 = g_stg[S-1].v_q;

  always_comb begin
    carry  = {g_f[WIDTH-2:0], c0_f};
    s_d    = p_f ^ carry;
    cout_d = g_f[WIDTH-1];
    ovf_d  = carry[WIDTH-1] ^ g_f[WIDTH-1];
    zero_d = ~|s_d;
  end

  logic             out_valid_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] s_q;
  logic [TAG_W-1:0] tag_q;

  // Data outputs only load on valid slots so they hold through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      tag_q       <= '0;
    end else if (en) begin
      out_valid_q <= v_f;
      if (v_f) begin
        s_q    <= s_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        tag_q  <= tag_f;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Self-checking bench: three configurations (16/1, 8/3, 64/2) share control and
// are compared every cycle against an arithmetic reference with latency bookkeeping.
module tb_prefix_addsub_pipe;

  localparam int unsigned ND = 3;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, in_valid, cin, sub;
  logic [3:0]  tag;
  logic [63:0] xv [ND];
  logic [63:0] yv [ND];

  logic        v16, v8, v64, c16, c8, c64, f16, f8, f64, z16, z8, z64;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [63:0] s64;
  logic [3:0]  t16, t8, t64;

  prefix_addsub_pipe #(.WIDTH(16), .LPS(1), .TAG_W(4)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .x(xv[0][15:0]), .y(yv[0][15:0]), .cin(cin), .sub(sub), .in_tag(tag),
    .out_valid(v16), .s(s16), .cout(c16), .ovf(f16), .zero(z16), .out_tag(t16)
  );

  prefix_addsub_pipe #(.WIDTH(8), .LPS(3), .TAG_W(4)) u_d8 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .x(xv[1][7:0]), .y(yv[1][7:0]), .cin(cin), .sub(sub), .in_tag(tag),
    .out_valid(v8), .s(s8), .cout(c8), .ovf(f8), .zero(z8), .out_tag(t8)
  );

  prefix_addsub_pipe #(.WIDTH(64), .LPS(2), .TAG_W(4)) u_d64 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .x(xv[2]), .y(yv[2]), .cin(cin), .sub(sub), .in_tag(tag),
    .out_valid(v64), .s(s64), .cout(c64), .ovf(f64), .zero(z64), .out_tag(t64)
  );

  int n_errors = 0;
  int n_checks = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned wid(input int unsigned d);
    case (d)
      0:       return 16;
      1:       return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int unsigned lat(input int unsigned d);
    case (d)
      0:       return 5;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] msk(input int unsigned w);
    logic [63:0] one = 64'd1;
    return (w >= 64) ? '1 : ((one << w) - 64'd1);
  endfunction

  function automatic logic [63:0] corner(input int unsigned k, input int unsigned w);
    logic [63:0] one = 64'd1;
    case (k)
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return msk(w);
      default: return one << (w - 1);
    endcase
  endfunction

  // Reference: integer and signed arithmetic on wide values, then reduce to w bits.
  function automatic res_t ref_op(input logic [63:0] a, input logic [63:0] b,
                                  input logic ci, input logic do_sub,
                                  input logic [3:0] t, input int unsigned w);
    res_t r;
    logic [67:0] ua, ub, uc, u;
    logic signed [67:0] sa, sbv, sc, sr, lim;
    ua  = {4'b0, a};
    ub  = {4'b0, b};
    uc  = {67'b0, ci};
    sa  = signed'(ua);
    sbv = signed'(ub);
    sc  = signed'(uc);
    lim = 68'sd1 <<< (w - 1);
    if (a[w-1]) sa = sa - (lim <<< 1);
    if (b[w-1]) sbv = sbv - (lim <<< 1);
    if (!do_sub) begin
      u      = ua + ub + uc;
      sr     = sa + sbv + sc;
      r.cout = (u >> w) != 68'd0;
    end else begin
      u      = ua - ub - uc;
      sr     = sa - sbv - sc;
      r.cout = ua >= (ub + uc);
    end
    r.ovf  = (sr >= lim) || (sr < -lim);
    r.s    = u[63:0] & msk(w);
    r.zero = (r.s == 64'd0);
    r.tag  = t;
    return r;
  endfunction

  function automatic res_t observed(input int unsigned d);
    res_t r;
    case (d)
      0: begin r.s = 64'(s16); r.cout = c16; r.ovf = f16; r.zero = z16; r.tag = t16; end
      1: begin r.s = 64'(s8);  r.cout = c8;  r.ovf = f8;  r.zero = z8;  r.tag = t8;  end
      default: begin r.s = s64; r.cout = c64; r.ovf = f64; r.zero = z64; r.tag = t64; end
    endcase
    return r;
  endfunction

  function automatic logic obs_valid(input int unsigned d);
    case (d)
      0:       return v16;
      1:       return v8;
      default: return v64;
    endcase
  endfunction

  // Expected results keyed by the enabled-edge count at which they must appear.
  logic        pend_v [ND][8];
  res_t        pend_r [ND][8];
  logic        exp_v  [ND];
  res_t        hold   [ND];
  int unsigned ecnt = 0;
  logic        last_rst, last_en;

  task automatic model_edge();
    int unsigned slot;
    last_rst = rst;
    last_en  = en;
    if (rst) begin
      for (int unsigned d = 0; d < ND; d++)
        for (int unsigned i = 0; i < 8; i++) pend_v[d][i] = 1'b0;
    end else if (en) begin
      ecnt++;
      for (int unsigned d = 0; d < ND; d++) begin
        slot = (ecnt + lat(d) - 1) % 8;
        pend_v[d][slot] = in_valid;
        if (in_valid) pend_r[d][slot] = ref_op(xv[d], yv[d], cin, sub, tag, wid(d));
      end
    end
  endtask

  task automatic check_all();
    int unsigned slot;
    res_t o;
    for (int unsigned d = 0; d < ND; d++) begin
      if (last_rst) begin
        exp_v[d] = 1'b0;
        hold[d]  = '0;
      end else if (last_en) begin
        slot     = ecnt % 8;
        exp_v[d] = pend_v[d][slot];
        if (pend_v[d][slot]) hold[d] = pend_r[d][slot];
        pend_v[d][slot] = 1'b0;
      end
      o = observed(d);
      check_eq($sformatf("d%0d.valid", d), 64'(obs_valid(d)), 64'(exp_v[d]));
      check_eq($sformatf("d%0d.s", d),     o.s,               hold[d].s);
      check_eq($sformatf("d%0d.cout", d),  64'(o.cout),       64'(hold[d].cout));
      check_eq($sformatf("d%0d.ovf", d),   64'(o.ovf),        64'(hold[d].ovf));
      check_eq($sformatf("d%0d.zero", d),  64'(o.zero),       64'(hold[d].zero));
      check_eq($sformatf("d%0d.tag", d),   64'(o.tag),        64'(hold[d].tag));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_ops(input int unsigned xk, input int unsigned yk);
    for (int unsigned d = 0; d < ND; d++) begin
      xv[d] = corner(xk, wid(d));
      yv[d] = corner(yk, wid(d));
    end
  endtask

  task automatic rand_op();
    in_valid = 1'b1;
    cin      = 1'($urandom);
    sub      = 1'($urandom);
    tag      = 4'($urandom);
    for (int unsigned d = 0; d < ND; d++) begin
      xv[d] = {$urandom, $urandom} & msk(wid(d));
      yv[d] = {$urandom, $urandom} & msk(wid(d));
    end
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned issued, cyc;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; cin = 1'b0; sub = 1'b0; tag = 4'd0;
    for (int unsigned d = 0; d < ND; d++) begin xv[d] = '0; yv[d] = '0; end
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // Directed ops with known 16-bit answers, issued back to back.
    in_valid = 1'b1; cin = 1'b0;
    set_ops(2, 1); sub = 1'b0; tag = 4'd3; step();
    set_ops(3, 1); sub = 1'b1; tag = 4'd5; step();
    set_ops(1, 1); yv[0] = 64'd2; yv[1] = 64'd2; yv[2] = 64'd2; tag = 4'd6; step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("add_ffff_1.valid", 64'(v16), 64'd1);
    check_eq("add_ffff_1.s",     64'(s16), 64'h0000);
    check_eq("add_ffff_1.cout",  64'(c16), 64'd1);
    check_eq("add_ffff_1.ovf",   64'(f16), 64'd0);
    check_eq("add_ffff_1.zero",  64'(z16), 64'd1);
    check_eq("add_ffff_1.tag",   64'(t16), 64'd3);
    step();
    check_eq("sub_8000_1.s",     64'(s16), 64'h7FFF);
    check_eq("sub_8000_1.cout",  64'(c16), 64'd1);
    check_eq("sub_8000_1.ovf",   64'(f16), 64'd1);
    check_eq("sub_8000_1.zero",  64'(z16), 64'd0);
    step();
    check_eq("sub_1_2.s",        64'(s16), 64'hFFFF);
    check_eq("sub_1_2.cout",     64'(c16), 64'd0);
    check_eq("sub_1_2.ovf",      64'(f16), 64'd0);
    idle(6);

    // 100 random ops with a bubble every 7th cycle.
    issued = 0;
    cyc    = 0;
    while (issued < 100) begin
      if (cyc % 7 == 6) begin
        in_valid = 1'b0;
      end else begin
        rand_op();
        issued++;
      end
      step();
      cyc++;
    end
    idle(8);

    // Stall with 4 ops in flight; inputs offered while stalled must be ignored.
    for (int i = 0; i < 4; i++) begin rand_op(); step(); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_op(); step(); end
    en = 1'b1;
    idle(8);

    // Reset with a full pipeline, overriding en and in_valid.
    for (int i = 0; i < 6; i++) begin rand_op(); step(); end
    rand_op();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rand_op();
    step();
    idle(8);
    for (int i = 0; i < 3; i++) begin rand_op(); step(); end
    en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    idle(8);

    // Corner operands against every cin/sub combination.
    in_valid = 1'b1;
    for (int unsigned xi = 0; xi < 4; xi++)
      for (int unsigned yi = 0; yi < 4; yi++)
        for (int unsigned cs = 0; cs < 4; cs++) begin
          set_ops(xi, yi);
          cin = cs[0];
          sub = cs[1];
          tag = 4'($urandom);
          step();
        end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prefix_addsub_pipe.md
Name: prefix_addsub_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Sklansky) adder/subtractor with valid and tag side-band and a global stall.
- Successor to the fixed 16-bit pipelined prefix adder: adds generic width, configurable prefix levels per pipeline stage, subtract mode, flags, reset, and throughput of one operation per cycle with per-slot valid tracking.
- Sits as the integer add/sub unit in the ALU datapath, feeding result/flag writeback.

Parameters:
- WIDTH, 32, operand width; power of two, 4..64.
- LPS, 1, prefix levels per pipeline stage; 1..log2(WIDTH).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance; 0 freezes every register, including valid and tag.
- in_valid  in  1  operation present on x/y/cin/sub/in_tag.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result valid.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB (subtract: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.
- out_tag  out  TAG_W  tag of the operation on s.

Behaviour:
- Operand conditioning: yb = sub ? ~y : y; c0 = cin ^ sub.
  - add: x + y + cin.
  - sub, cin = 0: x - y.
  - sub, cin = 1: x - y - 1.
- Pre-process: p = x ^ yb, g = x & yb. c0 is folded in as generate of bit -1.
- Prefix network:
  - Sklansky, N = log2(WIDTH) levels.
  - Group-PG operator: (G, P) = (Gh | Ph&Gl, Ph&Pl).
  - Carry into bit i = G[i-1:-1].
- Pipelining:
  - Register boundary after every LPS prefix levels. S = ceil(N/LPS) stages.
  - p, c0, tag and valid travel in delay registers beside the PG data.
- Post-process: s = p ^ carries; cout = G[WIDTH-1:-1]; ovf = carry_into_MSB ^ cout; zero = ~|s. These are registered into the output stage.
- Latency: LAT = S + 1 enabled cycles from an accepted input (in_valid = 1 and en = 1 at an edge) to out_valid = 1 with its result.
  - WIDTH = 16, LPS = 1: LAT = 5.
  - WIDTH = 32, LPS = 2: LAT = 4.
- Throughput: one operation per enabled cycle; back-to-back inputs produce back-to-back outputs, in order.
- in_valid = 0 while en = 1 injects a bubble: the matching out_valid is 0. Data outputs during bubbles are don't-care, but s/cout/ovf/zero/out_tag hold their last valid values.
- en = 0:
  - No register changes; outputs stable.
  - Inputs presented during en = 0 are ignored, not queued.
  - en is counted in cycles only when high.
- Reset (rst = 1 at edge):
  - All valid bits cleared; s, cout, ovf, zero, out_tag = 0.
  - Interior data registers need not clear.
  - rst overrides en and in_valid.
  - Reset mid-operation discards all in-flight operations. No out_valid occurs until LAT enabled cycles after the first accepted post-reset input.
- Wrap-around: results are modulo 2^WIDTH. Carry and overflow are reported only via cout/ovf; there is no saturation.

Test Plan:
- WIDTH=16, LPS=1, add x=0xFFFF, y=0x0001, cin=0, tag=3 -> 5 cycles later: out_valid=1, s=0x0000, cout=1, ovf=0, zero=1, out_tag=3.
- Sub x=0x8000, y=0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1, zero=0. Sub x=0x0001, y=0x0002 -> s=0xFFFF, cout=0, ovf=0.
- Stream 100 random ops back-to-back with a bubble every 7th cycle -> outputs match a reference model in order, and out_valid mirrors the input valid pattern delayed by LAT.
- Deassert en for 3 cycles with 4 ops in flight -> outputs frozen for those 3 cycles; all ops still emerge in order, LAT+3 cycles after issue.
- Assert rst for 1 cycle with the pipeline full -> next cycle out_valid=0, s=0, out_tag=0. A new op issued after reset appears exactly LAT cycles later; no stale results appear.
- Sweep WIDTH=8/LPS=3 (LAT=2) and WIDTH=64/LPS=2 (LAT=4) with exhaustive or random corner operands (0, 1, all-ones, MSB-only, cin/sub all 4 combos) -> all results match the model.
